// File: rtl/systolic_ctrl.sv
// systolic_ctrl: loads one weight tile into a ROWS x COLS weight-stationary PE
// array, then streams skewed activation vectors and flags valid column results.
module systolic_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int ADDR_W     = 10,
  parameter int VEC_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [VEC_W-1:0]           num_vecs,
  input  logic [ADDR_W-1:0]          w_base,
  input  logic [ADDR_W-1:0]          a_base,
  output logic                       busy,
  output logic                       done,
  output logic                       w_rd_en,
  output logic [ADDR_W-1:0]          w_rd_addr,
  input  logic [COLS*DATA_WIDTH-1:0] w_rd_data,
  output logic                       a_rd_en,
  output logic [ADDR_W-1:0]          a_rd_addr,
  input  logic [ROWS*DATA_WIDTH-1:0] a_rd_data,
  output logic                       array_en,
  output logic [COLS*DATA_WIDTH-1:0] col_weight,
  output logic [COLS-1:0]            col_accept_w,
  output logic [ROWS*DATA_WIDTH-1:0] row_input,
  output logic [ROWS-1:0]            row_valid,
  output logic [ROWS-1:0]            row_switch,
  output logic [COLS-1:0]            col_out_valid
);

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

  localparam logic [VEC_W-1:0]  LOAD_LAST  = VEC_W'(ROWS - 1);
  localparam logic [VEC_W-1:0]  DRAIN_LAST = VEC_W'(ROWS + COLS - 1);
  localparam logic [ADDR_W-1:0] W_TOP_OFS  = ADDR_W'(ROWS - 1);

  state_t                r_state, w_state_next;
  logic [VEC_W-1:0]      r_cnt, w_cnt_next;
  logic [VEC_W-1:0]      r_nv;
  logic [ADDR_W-1:0]     r_w_base, r_a_base;
  logic                  r_done, w_done_next;
  logic                  r_accept;
  logic [ROWS-1:0]       r_vld, r_sw;
  logic [COLS-1:0]       r_cov;
  logic                  w_load, w_stream, w_first_vec;
  logic [DATA_WIDTH-1:0] w_row_data [ROWS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_done  <= w_done_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nv     <= '0;
      r_w_base <= '0;
      r_a_base <= '0;
    end else if (r_state == IDLE && start) begin
      r_nv     <= num_vecs;
      r_w_base <= w_base;
      r_a_base <= a_base;
    end
  end

  // One shared counter indexes weight rows, vectors, then drain cycles.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (start) begin
          if (num_vecs == '0) w_done_next  = 1'b1;
          else                w_state_next = LOAD_W;
        end
      end
      LOAD_W: begin
        if (r_cnt == LOAD_LAST) begin
          w_state_next = STREAM;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + VEC_W'(1);
        end
      end
      STREAM: begin
        if (r_cnt == r_nv - VEC_W'(1)) begin
          w_state_next = DRAIN;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + VEC_W'(1);
        end
      end
      DRAIN: begin
        if (r_cnt == DRAIN_LAST) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
          w_done_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + VEC_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign w_load      = (r_state == LOAD_W);
  assign w_stream    = (r_state == STREAM);
  assign w_first_vec = w_stream && (r_cnt == '0);

  assign busy      = (r_state != IDLE);
  assign array_en  = busy;
  assign done      = r_done;
  assign w_rd_en   = w_load;
  assign w_rd_addr = w_load ? (r_w_base + W_TOP_OFS - ADDR_W'(r_cnt)) : '0;
  assign a_rd_en   = w_stream;
  assign a_rd_addr = w_stream ? (r_a_base + ADDR_W'(r_cnt)) : '0;

  // Valid/switch skew follows the SRAM read; column flags trail the bottom row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_accept <= 1'b0;
      r_vld    <= '0;
      r_sw     <= '0;
      r_cov    <= '0;
    end else begin
      r_accept <= w_load;
      r_vld    <= {r_vld[ROWS-2:0], w_stream};
      r_sw     <= {r_sw[ROWS-2:0], w_first_vec};
      r_cov    <= {r_cov[COLS-2:0], r_vld[ROWS-1]};
    end
  end

  assign col_accept_w  = {COLS{r_accept}};
  assign col_weight    = r_accept ? w_rd_data : '0;
  assign row_valid     = r_vld;
  assign row_switch    = r_sw;
  assign col_out_valid = r_cov;

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      if (gi == 0) begin : g_direct
        assign w_row_data[gi] = a_rd_data[DATA_WIDTH-1:0];
      end else begin : g_skew
        logic [DATA_WIDTH-1:0] r_skew [gi];
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int j = 0; j < gi; j++) r_skew[j] <= '0;
          end else begin
            r_skew[0] <= a_rd_data[gi*DATA_WIDTH +: DATA_WIDTH];
            for (int j = 1; j < gi; j++) r_skew[j] <= r_skew[j-1];
          end
        end
        assign w_row_data[gi] = r_skew[gi-1];
      end
      assign row_input[gi*DATA_WIDTH +: DATA_WIDTH] = r_vld[gi] ? w_row_data[gi] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: random jobs against a cycle-timing
// model derived from job parameters, plus literal checks on a reference job.
module tb_systolic_ctrl;
  localparam int DW = 32, R = 4, C = 4, AW = 10, VW = 16;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [VW-1:0] num_vecs = '0;
  logic [AW-1:0] w_base = '0, a_base = '0;
  logic busy, done, w_rd_en, a_rd_en, array_en;
  logic [AW-1:0] w_rd_addr, a_rd_addr;
  logic [C*DW-1:0] w_rd_data, col_weight;
  logic [R*DW-1:0] a_rd_data, row_input;
  logic [C-1:0] col_accept_w, col_out_valid;
  logic [R-1:0] row_valid, row_switch;

  logic [C*DW-1:0] wmem [1024];
  logic [R*DW-1:0] amem [1024];
  int cyc = 0, tests = 0, fails = 0;

  systolic_ctrl #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C), .ADDR_W(AW), .VEC_W(VW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vecs(num_vecs), .w_base(w_base),
    .a_base(a_base), .busy(busy), .done(done), .w_rd_en(w_rd_en),
    .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data), .a_rd_en(a_rd_en),
    .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data), .array_en(array_en),
    .col_weight(col_weight), .col_accept_w(col_accept_w), .row_input(row_input),
    .row_valid(row_valid), .row_switch(row_switch), .col_out_valid(col_out_valid));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAMs: one-cycle read latency, garbage on the bus when not reading
  always @(posedge clk) begin
    w_rd_data <= w_rd_en ? wmem[w_rd_addr] : {$urandom, $urandom, $urandom, $urandom};
    a_rd_data <= a_rd_en ? amem[a_rd_addr] : {$urandom, $urandom, $urandom, $urandom};
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    bit            act;
    int            s;
    int            nv;
    logic [AW-1:0] wb;
    logic [AW-1:0] ab;
  } job_t;

  job_t jp, jc;
  logic e_busy, e_done, e_wen, e_aen, e_arr;
  logic [AW-1:0] e_waddr, e_aaddr;
  logic [C*DW-1:0] e_cw;
  logic [R*DW-1:0] e_ri;
  logic [C-1:0] e_acc, e_cov;
  logic [R-1:0] e_rv, e_rs;

  // Expected outputs in cycle t from a job accepted in cycle j.s
  task automatic contrib(input job_t j, input int t);
    int l0, a0, d, k;
    logic [AW-1:0] ad;
    if (!j.act) return;
    if (j.nv == 0) begin
      if (t == j.s + 1) e_done = 1'b1;
      return;
    end
    l0 = j.s + 1;
    a0 = l0 + R;
    d  = a0 + j.nv + R + C;
    if (t == d) e_done = 1'b1;
    if (t >= l0 && t < d) begin e_busy = 1'b1; e_arr = 1'b1; end
    if (t >= l0 && t < l0 + R) begin
      e_wen = 1'b1;
      e_waddr = j.wb + AW'(R - 1 - (t - l0));
    end
    if (t > l0 && t <= l0 + R) begin
      ad = j.wb + AW'(R - (t - l0));
      e_acc = '1;
      e_cw = wmem[ad];
    end
    if (t >= a0 && t < a0 + j.nv) begin
      e_aen = 1'b1;
      e_aaddr = j.ab + AW'(t - a0);
    end
    for (int r = 0; r < R; r++) begin
      k = t - a0 - 1 - r;
      if (k >= 0 && k < j.nv) begin
        ad = j.ab + AW'(k);
        e_rv[r] = 1'b1;
        e_ri[r*DW +: DW] = amem[ad][r*DW +: DW];
        if (k == 0) e_rs[r] = 1'b1;
      end
    end
    for (int c = 0; c < C; c++) begin
      k = t - a0 - 1 - R - c;
      if (k >= 0 && k < j.nv) e_cov[c] = 1'b1;
    end
  endtask

  function automatic bit model_idle(input int t);
    return !jc.act || jc.nv == 0 || t >= jc.s + 1 + R + jc.nv + R + C;
  endfunction

  initial begin
    jp = '{1'b0, 0, 0, '0, '0};
    jc = '{1'b0, 0, 0, '0, '0};
    forever begin
      @(negedge clk);
      e_busy = 0; e_done = 0; e_wen = 0; e_aen = 0; e_arr = 0;
      e_waddr = '0; e_aaddr = '0; e_cw = '0; e_ri = '0;
      e_acc = '0; e_cov = '0; e_rv = '0; e_rs = '0;
      if (rst) begin
        jp.act = 1'b0;
        jc.act = 1'b0;
      end else begin
        contrib(jp, cyc);
        contrib(jc, cyc);
      end
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("array_en", array_en, e_arr);
      chk("w_rd_en", w_rd_en, e_wen);
      chk("w_rd_addr", w_rd_addr, e_waddr);
      chk("a_rd_en", a_rd_en, e_aen);
      chk("a_rd_addr", a_rd_addr, e_aaddr);
      chk("col_accept_w", col_accept_w, e_acc);
      chk("col_weight", col_weight, e_cw);
      chk("row_valid", row_valid, e_rv);
      chk("row_switch", row_switch, e_rs);
      chk("row_input", row_input, e_ri);
      chk("col_out_valid", col_out_valid, e_cov);
      if (!rst && start && model_idle(cyc)) begin
        jp = jc;
        jc = '{1'b1, cyc, int'(num_vecs), w_base, a_base};
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin @(posedge clk); #1; n++; end
    chk("idle_timeout", busy, 1'b0);
  endtask

  // Waits for done; optionally pulses an ignored start while the job is busy
  task automatic wait_done(input int pulse_at);
    int n = 0;
    while (!done && n < 300) begin
      if (n == pulse_at) begin
        start = 1'b1;
        num_vecs = VW'($urandom_range(1, 9));
        w_base = AW'($urandom);
        a_base = AW'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk("done_timeout", done, 1'b1);
  endtask

  task automatic directed(input int nv);
    logic [AW-1:0] wq[$], aq[$];
    logic [AW-1:0] w_exp [4] = '{10'h13, 10'h12, 10'h11, 10'h10};
    logic [AW-1:0] a_exp [3] = '{10'h40, 10'h41, 10'h42};
    int s, dc = -1, sw3 = -1, rv3 = -1, cv3 = -1;
    bit bseen = 0;
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1; num_vecs = VW'(nv); w_base = 10'h10; a_base = 10'h40; s = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (w_rd_en) wq.push_back(w_rd_addr);
      if (a_rd_en) aq.push_back(a_rd_addr);
      if (done && dc < 0) dc = cyc;
      if (row_switch[3] && sw3 < 0) sw3 = cyc;
      if (row_valid[3] && rv3 < 0) rv3 = cyc;
      if (col_out_valid[3] && cv3 < 0) cv3 = cyc;
      if (busy) bseen = 1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (nv == 0) begin
      chk("zero_w_reads", wq.size(), 0);
      chk("zero_a_reads", aq.size(), 0);
      chk("zero_done_latency", dc - s, 1);
      chk("zero_busy_seen", bseen, 1'b0);
    end else begin
      chk("w_seq_len", wq.size(), 4);
      for (int i = 0; i < 4; i++) if (i < wq.size()) chk("w_seq_addr", wq[i], w_exp[i]);
      chk("a_seq_len", aq.size(), 3);
      for (int i = 0; i < 3; i++) if (i < aq.size()) chk("a_seq_addr", aq[i], a_exp[i]);
      chk("done_latency", dc - s, 16);
      chk("row3_switch_cycle", sw3 - s, 9);
      chk("row3_valid_cycle", rv3 - s, 9);
      chk("col3_out_cycle", cv3 - s, 13);
      chk("busy_seen", bseen, 1'b1);
    end
  endtask

  initial begin
    int n, dcount;
    for (int i = 0; i < 1024; i++) begin
      wmem[i] = {$urandom, $urandom, $urandom, $urandom};
      amem[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outputs", {busy, done, w_rd_en, a_rd_en, array_en, row_valid, col_out_valid}, '0);

    directed(3);
    directed(0);

    // Abort a job mid-stream with an asynchronous reset
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1; num_vecs = VW'(8); w_base = AW'($urandom); a_base = AW'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!a_rd_en && n < 50) begin @(posedge clk); #1; n++; end
    chk("reach_stream", a_rd_en, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_outputs_zero",
        {busy, done, w_rd_en, a_rd_en, array_en, col_accept_w, row_valid, row_switch,
         col_out_valid, |row_input, |col_weight}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    dcount = 0;
    repeat (30) begin @(negedge clk); if (done) dcount++; end
    chk("abort_no_done", dcount, 0);

    directed(3);

    // Random jobs, with ignored mid-job starts and starts in the done cycle
    wait_idle();
    @(posedge clk); #1;
    for (int j = 0; j < 30; j++) begin
      int nv;
      nv = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 10));
      start = 1'b1;
      num_vecs = VW'(nv);
      w_base = (j % 4 == 1) ? AW'(1022) : AW'($urandom);
      a_base = (j % 5 == 0) ? AW'(1020) : AW'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(int'($urandom_range(1, 12)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    wait_idle();
    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
